// File: rtl/lvds_capture_trigger_pkg.sv
// Shared definitions for the LVDS capture trigger.
//   state_t        : capture controller state encoding
//   MODE_*         : trigger source selection values for cfg_mode
//   sat_inc16      : 16-bit saturating increment used for the trigger counter
package lvds_capture_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_IMM  = 2'd0;
    localparam logic [1:0] MODE_RISE = 2'd1;
    localparam logic [1:0] MODE_FALL = 2'd2;
    localparam logic [1:0] MODE_EXT  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lvds_capture_trigger_toggle_sync.sv
// Two-flop synchroniser followed by an edge detector.
//   clklvds : destination clock
//   rstn    : asynchronous active-low reset
//   din     : asynchronous level input
//   pulse   : one-cycle pulse per detected edge
// EDGE_ANY=1 reports both edges (toggle handshake), EDGE_ANY=0 reports
// rising edges only (level trigger input).
module lvds_capture_trigger_toggle_sync #(
    parameter bit EDGE_ANY = 1'b1
) (
    input  logic clklvds,
    input  logic rstn,
    input  logic din,
    output logic pulse
);

    // [0],[1] form the synchroniser; [2] holds the previous synchronised value.
    logic [2:0] sync_q;

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign pulse = EDGE_ANY ? (sync_q[1] ^ sync_q[2]) : (sync_q[1] & ~sync_q[2]);

endmodule

// File: rtl/lvds_capture_trigger.sv
// Capture controller between the deserialised LVDS lanes and the capture
// FIFO write port, running entirely in the clklvds domain.
//   din, fifo_wrused           : sample lanes in, FIFO fill level in
//   fifo_wr, fifo_data         : FIFO write port
//   arm_toggle, done_toggle    : toggle handshakes with the command domain
//   cfg_*                      : capture configuration, latched on each arm
//   ext_trig                   : asynchronous external trigger
//   busy, triggered, overflow, trig_count : status
//
// state   | meaning
// IDLE    | waiting for an arm request
// ARMED   | config latched, waiting for the trigger condition
// CAPTURE | writing cfg_length words to the FIFO
module lvds_capture_trigger
    import lvds_capture_trigger_pkg::*;
#(
    parameter int NLANE        = 14,
    parameter int SAMPLE_W     = 10,
    parameter int USED_W       = 11,
    parameter int AFULL_THRESH = 1020,
    parameter int LEN_W        = 32,
    localparam int DIN_W       = NLANE * SAMPLE_W
) (
    input  logic                clklvds,
    input  logic                rstn,
    input  logic [DIN_W-1:0]    din,
    input  logic [USED_W-1:0]   fifo_wrused,
    output logic                fifo_wr,
    output logic [DIN_W-1:0]    fifo_data,
    input  logic                arm_toggle,
    input  logic [1:0]          cfg_mode,
    input  logic [3:0]          cfg_lane,
    input  logic [SAMPLE_W-1:0] cfg_threshold,
    input  logic [LEN_W-1:0]    cfg_length,
    input  logic                cfg_autorearm,
    input  logic                cfg_testpattern,
    input  logic                ext_trig,
    output logic                busy,
    output logic                triggered,
    output logic                overflow,
    output logic [15:0]         trig_count,
    output logic                done_toggle
);

    localparam logic [USED_W-1:0] AFULL_L = USED_W'(AFULL_THRESH);

    state_t              state;
    logic                arm_pulse;
    logic                ext_pulse;

    logic [DIN_W-1:0]    s1;
    logic [DIN_W-1:0]    s2;

    logic [1:0]          mode_q;
    logic [3:0]          lane_q;
    logic [SAMPLE_W-1:0] thr_q;
    logic [LEN_W-1:0]    len_q;
    logic                autorearm_q;
    logic                testpattern_q;

    logic [LEN_W-1:0]    wr_count;
    logic [LEN_W-1:0]    wr_next;
    logic [SAMPLE_W-1:0] pat_cnt;
    logic [DIN_W-1:0]    pat_word;

    logic [SAMPLE_W-1:0] cur_lane;
    logic [SAMPLE_W-1:0] prev_lane;
    logic                trig_hit;

    lvds_capture_trigger_toggle_sync #(.EDGE_ANY(1'b1)) u_arm_sync (
        .clklvds (clklvds),
        .rstn    (rstn),
        .din     (arm_toggle),
        .pulse   (arm_pulse)
    );

    lvds_capture_trigger_toggle_sync #(.EDGE_ANY(1'b0)) u_ext_sync (
        .clklvds (clklvds),
        .rstn    (rstn),
        .din     (ext_trig),
        .pulse   (ext_pulse)
    );

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    always_comb begin
        cur_lane  = '0;
        prev_lane = '0;
        for (int k = 0; k < NLANE; k++) begin
            if (lane_q == 4'(k)) begin
                cur_lane  = s1[k*SAMPLE_W +: SAMPLE_W];
                prev_lane = s2[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            MODE_IMM:  trig_hit = 1'b1;
            MODE_RISE: trig_hit = (prev_lane <  thr_q) && (cur_lane >= thr_q);
            MODE_FALL: trig_hit = (prev_lane >= thr_q) && (cur_lane <  thr_q);
            MODE_EXT:  trig_hit = ext_pulse;
            default:   trig_hit = 1'b0;
        endcase
    end

    assign wr_next  = wr_count + 1'b1;
    assign pat_word = {NLANE{pat_cnt}};

    // The trigger decision is taken on s1 in ARMED; by the first CAPTURE
    // cycle that sample has moved to s2, so CAPTURE writes from s2 and the
    // trigger sample becomes the first word written.
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            fifo_wr       <= 1'b0;
            fifo_data     <= '0;
            overflow      <= 1'b0;
            trig_count    <= '0;
            done_toggle   <= 1'b0;
            mode_q        <= MODE_IMM;
            lane_q        <= '0;
            thr_q         <= '0;
            len_q         <= '0;
            autorearm_q   <= 1'b0;
            testpattern_q <= 1'b0;
            wr_count      <= '0;
            pat_cnt       <= '0;
        end else begin
            fifo_wr <= 1'b0;
            if (arm_pulse) begin
                // Arm from any state; in ARMED/CAPTURE this is an abort and
                // deliberately produces no done indication.
                mode_q        <= cfg_mode;
                lane_q        <= (int'(cfg_lane) < NLANE) ? cfg_lane : 4'd0;
                thr_q         <= cfg_threshold;
                len_q         <= cfg_length;
                autorearm_q   <= cfg_autorearm;
                testpattern_q <= cfg_testpattern;
                overflow      <= 1'b0;
                trig_count    <= '0;
                pat_cnt       <= '0;
                wr_count      <= '0;
                state         <= ARMED;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            trig_count <= sat_inc16(trig_count);
                            wr_count   <= '0;
                            if (len_q == '0) begin
                                done_toggle <= ~done_toggle;
                                state       <= autorearm_q ? ARMED : IDLE;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (fifo_wrused < AFULL_L) begin
                            fifo_wr   <= 1'b1;
                            fifo_data <= testpattern_q ? pat_word : s2;
                            pat_cnt   <= pat_cnt + 1'b1;
                            wr_count  <= wr_next;
                            if (wr_next == len_q) begin
                                done_toggle <= ~done_toggle;
                                state       <= autorearm_q ? ARMED : IDLE;
                            end
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign triggered = (state == CAPTURE);

endmodule

// File: tb/tb_lvds_capture_trigger.sv
// Directed self-checking bench for lvds_capture_trigger.
module tb_lvds_capture_trigger;

    localparam int NLANE = 14;
    localparam int SW    = 10;
    localparam int DW    = NLANE * SW;

    logic          clklvds = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] din = '0;
    logic [10:0]   fifo_wrused = '0;
    logic          fifo_wr;
    logic [DW-1:0] fifo_data;
    logic          arm_toggle = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [3:0]    cfg_lane = 4'd0;
    logic [SW-1:0] cfg_threshold = '0;
    logic [31:0]   cfg_length = '0;
    logic          cfg_autorearm = 1'b0;
    logic          cfg_testpattern = 1'b0;
    logic          ext_trig = 1'b0;
    logic          busy;
    logic          triggered;
    logic          overflow;
    logic [15:0]   trig_count;
    logic          done_toggle;

    lvds_capture_trigger dut (
        .clklvds         (clklvds),
        .rstn            (rstn),
        .din             (din),
        .fifo_wrused     (fifo_wrused),
        .fifo_wr         (fifo_wr),
        .fifo_data       (fifo_data),
        .arm_toggle      (arm_toggle),
        .cfg_mode        (cfg_mode),
        .cfg_lane        (cfg_lane),
        .cfg_threshold   (cfg_threshold),
        .cfg_length      (cfg_length),
        .cfg_autorearm   (cfg_autorearm),
        .cfg_testpattern (cfg_testpattern),
        .ext_trig        (ext_trig),
        .busy            (busy),
        .triggered       (triggered),
        .overflow        (overflow),
        .trig_count      (trig_count),
        .done_toggle     (done_toggle)
    );

    always #5 clklvds = ~clklvds;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit din_auto = 1'b0;

    logic [DW-1:0] hist [0:4095];
    logic [DW-1:0] wq [$];
    int            wcyc [$];
    int            flips = 0;
    int            flip_cyc = 0;
    logic          last_done = 1'b0;

    always @(posedge clklvds) cyc <= cyc + 1;

    function automatic logic [DW-1:0] auto_word(input int c);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NLANE; k++) r[k*SW +: SW] = SW'((c * 7 + k * 37) % 1024);
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_word(input int k, input int v);
        logic [DW-1:0] r;
        r = '0;
        r[k*SW +: SW] = SW'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] rep(input int p);
        logic [DW-1:0] r;
        for (int k = 0; k < NLANE; k++) r[k*SW +: SW] = SW'(p);
        return r;
    endfunction

    // din as seen by the DUT at the following rising edge
    always @(negedge clklvds) hist[cyc % 4096] = din;

    always @(posedge clklvds) begin
        #2;
        if (din_auto) din = auto_word(cyc);
    end

    always @(posedge clklvds) begin
        #1;
        if (fifo_wr === 1'b1) begin
            wq.push_back(fifo_data);
            wcyc.push_back(cyc);
        end
        if (done_toggle !== last_done) begin
            flips++;
            flip_cyc = cyc;
        end
        last_done = done_toggle;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clklvds);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        flips = 0;
    endtask

    task automatic wait_flips(input int target, input int budget);
        for (int i = 0; i < budget && flips < target; i++) tick(1);
        chk("done_timeout", (flips >= target), 1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int i = 0; i < budget && wq.size() < target; i++) tick(1);
        chk("write_timeout", (wq.size() >= target), 1);
    endtask

    task automatic verify_din_words(input string tag);
        for (int i = 0; i < wq.size(); i++) chk(tag, wq[i], hist[(wcyc[i] - 3) % 4096]);
    endtask

    int tcyc;
    int d0;

    initial begin
        rstn = 1'b0;
        tick(2);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_trig_count", trig_count, 0);
        chk("rst_done", done_toggle, 0);
        rstn = 1'b1;
        tick(2);

        // Immediate mode, length 8
        din_auto = 1'b1;
        cfg_mode = 2'd0; cfg_length = 8; cfg_testpattern = 0; cfg_autorearm = 0;
        clear_mon();
        tcyc = cyc;
        arm_toggle = ~arm_toggle;
        tick(2);
        chk("t1_busy_early", busy, 0);
        tick(1);
        chk("t1_busy_3cyc", busy, 1);
        tick(1);
        chk("t1_triggered", triggered, 1);
        wait_flips(1, 40);
        chk("t1_nwrites", wq.size(), 8);
        chk("t1_first_lat", wcyc[0] - tcyc, 5);
        chk("t1_contiguous", wcyc[7] - wcyc[0], 7);
        verify_din_words("t1_word");
        chk("t1_busy_end", busy, 0);
        chk("t1_trig_count", trig_count, 1);
        tick(3);
        chk("t1_single_done", flips, 1);

        // Rising threshold on lane 2
        din_auto = 1'b0;
        din = '0;
        cfg_mode = 2'd1; cfg_lane = 4'd2; cfg_threshold = 10'd512; cfg_length = 2;
        clear_mon();
        arm_toggle = ~arm_toggle;
        tick(4);
        for (int v = 500; v <= 530; v += 5) begin
            din = lane_word(2, v);
            tick(1);
        end
        wait_flips(1, 20);
        chk("t2_nwrites", wq.size(), 2);
        chk("t2_first_word", wq[0], lane_word(2, 515));
        chk("t2_second_word", wq[1], lane_word(2, 520));
        chk("t2_trig_count", trig_count, 1);

        // Falling threshold on lane 0
        din = lane_word(0, 120);
        cfg_mode = 2'd2; cfg_lane = 4'd0; cfg_threshold = 10'd100; cfg_length = 1;
        clear_mon();
        arm_toggle = ~arm_toggle;
        tick(4);
        din = lane_word(0, 130); tick(1);
        din = lane_word(0, 101); tick(1);
        din = lane_word(0, 100); tick(1);
        din = lane_word(0, 150); tick(1);
        din = lane_word(0, 100); tick(3);
        chk("t3_no_write", wq.size(), 0);
        chk("t3_still_armed", busy, 1);
        din = lane_word(0, 120); tick(1);
        din = lane_word(0, 99);
        wait_flips(1, 20);
        chk("t3_nwrites", wq.size(), 1);
        chk("t3_word", wq[0], lane_word(0, 99));
        chk("t3_busy_end", busy, 0);

        // Backpressure: unstalled reference then 3 stalled cycles
        din_auto = 1'b1;
        cfg_mode = 2'd0; cfg_length = 4;
        clear_mon();
        tcyc = cyc;
        arm_toggle = ~arm_toggle;
        wait_flips(1, 40);
        d0 = flip_cyc - tcyc;
        chk("t4_ref_nwrites", wq.size(), 4);
        chk("t4_ref_overflow", overflow, 0);
        clear_mon();
        tcyc = cyc;
        arm_toggle = ~arm_toggle;
        tick(5);
        fifo_wrused = 11'd1020;
        tick(3);
        fifo_wrused = 11'd0;
        wait_flips(1, 40);
        chk("t4_overflow", overflow, 1);
        chk("t4_nwrites", wq.size(), 4);
        chk("t4_delay", (flip_cyc - tcyc) - d0, 3);
        verify_din_words("t4_word");

        // Test pattern with autorearm, then async reset mid-capture
        cfg_testpattern = 1; cfg_autorearm = 1; cfg_length = 3;
        clear_mon();
        arm_toggle = ~arm_toggle;
        wait_writes(6, 40);
        chk("t5_trig_count", trig_count, 2);
        chk("t5_flips", flips, 2);
        chk("t5_overflow_cleared", overflow, 0);
        for (int i = 0; i < 6; i++) chk("t5_pattern", wq[i], rep(i));
        tick(2);
        chk("t5_in_capture", triggered, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_fifo_wr", fifo_wr, 0);
        chk("t5_rst_fifo_data", fifo_data, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_triggered", triggered, 0);
        chk("t5_rst_trig_count", trig_count, 0);
        chk("t5_rst_done", done_toggle, 0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Length 0
        cfg_testpattern = 0; cfg_autorearm = 0; cfg_length = 0;
        clear_mon();
        arm_toggle = ~arm_toggle;
        wait_flips(1, 20);
        tick(2);
        chk("t6_no_write", wq.size(), 0);
        chk("t6_flips", flips, 1);
        chk("t6_busy", busy, 0);

        // Re-arm during capture aborts without a done indication
        cfg_length = 8;
        clear_mon();
        arm_toggle = ~arm_toggle;
        tick(5);
        cfg_length = 4;
        arm_toggle = ~arm_toggle;
        wait_flips(1, 40);
        tick(5);
        chk("t7_flips", flips, 1);
        chk("t7_nwrites", wq.size(), 7);
        chk("t7_trig_count", trig_count, 1);
        chk("t7_busy", busy, 0);
        verify_din_words("t7_word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
